// File: rtl/esp_trees_pkg.sv
// Shared types and constants for the trees accelerator DMA stages:
// write-back state encoding, DMA request constants and beat-count helper.
package esp_trees_pkg;

  localparam int PRED_WIDTH    = 32;
  localparam int DMA_WIDTH     = 64;
  localparam int MAX_BURST_DEF = 5000;

  localparam logic [2:0] DMA_SIZE_DWORD = 3'b011;
  localparam int         DMA_USER_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    CTRL,
    DATA,
    FIN
  } wb_state_e;

  // Two predictions per beat, rounded up, plus any trailer beats.
  function automatic logic [31:0] beats_for(input logic [31:0] samples,
                                            input logic [31:0] extra);
    return ((samples + 32'd1) >> 1) + extra;
  endfunction

endpackage

// File: rtl/pred_beat_fifo.sv
// Synchronous W x DEPTH beat FIFO (DEPTH a power of two); a pop on a full
// FIFO frees the slot for a push in the same cycle.
module pred_beat_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int           AW        = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; empty/full come only from the pointers and
  // count, so stale entries are never observable and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/esp_pred_writeback.sv
// Prediction write-back: packs two predictions per DMA beat and drives the
// ESP DMA write interfaces. Define PRED_WB_TRAILER_EN for a checksum trailer.
module esp_pred_writeback
  import esp_trees_pkg::*;
#(
  parameter int MAX_BURST  = MAX_BURST_DEF,
  parameter int PRED_W     = PRED_WIDTH,
  parameter int DMA_W      = DMA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       burst_len,
  input  logic [31:0]       wr_base_index,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [PRED_W-1:0] pred_data,
  output logic              dma_write_ctrl_valid,
  input  logic              dma_write_ctrl_ready,
  output logic [31:0]       dma_write_ctrl_data_index,
  output logic [31:0]       dma_write_ctrl_data_length,
  output logic [2:0]        dma_write_ctrl_data_size,
  output logic [5:0]        dma_write_ctrl_data_user,
  output logic              dma_write_chnl_valid,
  input  logic              dma_write_chnl_ready,
  output logic [DMA_W-1:0]  dma_write_chnl_data,
  output logic              busy,
  output logic              done
);

`ifdef PRED_WB_TRAILER_EN
  localparam logic [31:0] TRAILER_BEATS = 32'd1;
`else
  localparam logic [31:0] TRAILER_BEATS = 32'd0;
`endif

  wb_state_e state, state_nxt;

  logic [31:0]       len_r, base_r, beats_r, acc_cnt, sent_cnt;
  logic [31:0]       len_sat, start_beats;
  logic [PRED_W-1:0] hold_lo;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_room;
  logic              samples_left, pred_fire, last_sample, data_push;
  logic [DMA_W-1:0]  data_beat, push_beat;

  assign len_sat     = (burst_len > 32'(MAX_BURST)) ? 32'(MAX_BURST) : burst_len;
  assign start_beats = beats_for(len_sat, TRAILER_BEATS);

  assign fifo_pop     = dma_write_chnl_valid & dma_write_chnl_ready;
  assign fifo_room    = ~fifo_full | fifo_pop;
  assign samples_left = (acc_cnt < len_r);
  assign pred_ready   = (state == DATA) & samples_left & fifo_room;
  assign pred_fire    = pred_valid & pred_ready;

  // An odd sample completes a pair; a trailing even sample is padded with zero.
  assign last_sample = (acc_cnt + 32'd1 == len_r);
  assign data_push   = pred_fire & (acc_cnt[0] | last_sample);
  assign data_beat   = acc_cnt[0] ? {pred_data, hold_lo}
                                  : {{PRED_W{1'b0}}, pred_data};

`ifdef PRED_WB_TRAILER_EN
  logic [PRED_W-1:0] csum;
  logic              trl_sent, trl_push;

  assign trl_push  = (state == DATA) & ~samples_left & ~trl_sent & fifo_room;
  assign fifo_push = data_push | trl_push;
  assign push_beat = trl_push ? {csum, acc_cnt[PRED_W-1:0]} : data_beat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      csum     <= '0;
      trl_sent <= 1'b0;
    end else if (state == IDLE && start) begin
      csum     <= '0;
      trl_sent <= 1'b0;
    end else begin
      if (pred_fire) csum     <= csum + pred_data;
      if (trl_push)  trl_sent <= 1'b1;
    end
  end
`else
  assign fifo_push = data_push;
  assign push_beat = data_beat;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: defaulting state_nxt before the case keeps this block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (start_beats == '0) ? FIN : CTRL;
      CTRL: if (dma_write_ctrl_ready) state_nxt = DATA;
      DATA: if (fifo_pop && (sent_cnt + 32'd1 == beats_r)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_r    <= '0;
      base_r   <= '0;
      beats_r  <= '0;
      acc_cnt  <= '0;
      sent_cnt <= '0;
      hold_lo  <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_r    <= len_sat;
        base_r   <= wr_base_index;
        beats_r  <= start_beats;
        acc_cnt  <= '0;
        sent_cnt <= '0;
      end
      if (pred_fire) begin
        acc_cnt <= acc_cnt + 32'd1;
        if (!acc_cnt[0]) hold_lo <= pred_data;
      end
      if (fifo_pop) sent_cnt <= sent_cnt + 32'd1;
    end
  end

  pred_beat_fifo #(
    .W     (DMA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_beat),
    .pop       (fifo_pop),
    .pop_data  (dma_write_chnl_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dma_write_ctrl_valid       = (state == CTRL);
  assign dma_write_ctrl_data_index  = base_r;
  assign dma_write_ctrl_data_length = beats_r;
  assign dma_write_ctrl_data_size   = DMA_SIZE_DWORD;
  assign dma_write_ctrl_data_user   = '0;
  assign dma_write_chnl_valid       = ~fifo_empty;
  assign busy                       = (state == CTRL) | (state == DATA);
  assign done                       = (state == FIN);

endmodule

// File: tb/tb_esp_pred_writeback.sv
// Directed bench for esp_pred_writeback with an expected-beat scoreboard
// filled from accepted predictions and drained by DMA channel handshakes.
module tb_esp_pred_writeback;

`ifdef PRED_WB_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] burst_len, wr_base_index;
  logic        pred_valid, pred_ready;
  logic [31:0] pred_data;
  logic        dma_write_ctrl_valid, dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic [5:0]  dma_write_ctrl_data_user;
  logic        dma_write_chnl_valid, dma_write_chnl_ready;
  logic [63:0] dma_write_chnl_data;
  logic        busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] preds[0:5099];

  always #5 clk = ~clk;

  esp_pred_writeback dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .burst_len                  (burst_len),
    .wr_base_index              (wr_base_index),
    .pred_valid                 (pred_valid),
    .pred_ready                 (pred_ready),
    .pred_data                  (pred_data),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_ctrl_data_user   (dma_write_ctrl_data_user),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .busy                       (busy),
    .done                       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    pred_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl_valid", 64'(dma_write_ctrl_valid), 64'd0);
    chk("rst_chnl_valid", 64'(dma_write_chnl_valid), 64'd0);
    chk("rst_pred_ready", 64'(pred_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_index", 64'(dma_write_ctrl_data_index), 64'd0);
    chk("rst_length", 64'(dma_write_ctrl_data_length), 64'd0);
    rst = 1'b1;
    pred_valid = 1'b0;
    dma_write_ctrl_ready = 1'b0;
    dma_write_chnl_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_done", 64'(done), 64'd0);
  endtask

  // One run: start at cycle 0, ctrl_ready from cycle ctrl_stall, chnl_ready
  // asserted rdy_pct% of cycles; abort_beats>0 stops after that many beats.
  task automatic run(input int len, input int base, input int rdy_pct,
                     input int ctrl_stall, input int abort_beats);
    int          acc, beats, done_cnt, done_cyc, last_cyc, exp_len, cyc;
    bit          ctrl_seen;
    logic [31:0] sum;
    acc = 0; beats = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
    ctrl_seen = 1'b0; sum = '0;
    exp_len = (len + 1) / 2 + TRL;
    if (TRL == 1 && len == 0) exp_q.push_back(64'h0);
    for (cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clk);
      start                = (cyc == 0);
      burst_len            = 32'(len);
      wr_base_index        = 32'(base);
      dma_write_ctrl_ready = (cyc >= ctrl_stall);
      dma_write_chnl_ready = ($urandom_range(99) < 32'(rdy_pct));
      pred_valid           = (cyc > 0);
      pred_data            = preds[acc];
      #1;
      if (dma_write_ctrl_valid) begin
        chk("ctrl_pred_ready", 64'(pred_ready), 64'd0);
        chk("ctrl_index", 64'(dma_write_ctrl_data_index), 64'(base));
        chk("ctrl_length", 64'(dma_write_ctrl_data_length), 64'(exp_len));
        if (dma_write_ctrl_ready) begin
          chk("ctrl_size", 64'(dma_write_ctrl_data_size), 64'd3);
          chk("ctrl_user", 64'(dma_write_ctrl_data_user), 64'd0);
          ctrl_seen = 1'b1;
        end
      end
      if (pred_valid && pred_ready) begin
        sum = sum + pred_data;
        if (acc % 2 == 1)
          exp_q.push_back({pred_data, preds[acc-1]});
        else if (acc == len - 1)
          exp_q.push_back({32'h0, pred_data});
        if (TRL == 1 && acc == len - 1) exp_q.push_back({sum, 32'(len)});
        acc++;
      end
      if (dma_write_chnl_valid && dma_write_chnl_ready) begin
        chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("beat_data", dma_write_chnl_data, exp_q.pop_front());
        beats++;
        last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort_beats > 0 && beats == abort_beats) break;
      if (done_cnt > 0 && cyc > done_cyc) break;
    end
    start = 1'b0;
    if (abort_beats > 0) begin
      chk("abort_no_done", 64'(done_cnt), 64'd0);
    end else begin
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("beat_count", 64'(beats), 64'(exp_len));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("accepted", 64'(acc), 64'(len));
      chk("ctrl_issued", 64'(ctrl_seen), 64'(exp_len > 0));
      if (exp_len > 0)
        chk("done_after_last_beat", 64'(done_cyc), 64'(last_cyc + 1));
      else
        chk("done_latency_le2", 64'(done_cyc >= 1 && done_cyc <= 2), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; wr_base_index = '0;
    pred_valid = 1'b0; pred_data = '0;
    dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
    for (int i = 0; i < 5100; i++) preds[i] = $urandom;
    do_reset();

    // Even length, full throughput.
    preds[0] = 32'd1; preds[1] = 32'd2; preds[2] = 32'd3; preds[3] = 32'd4;
    run(4, 100, 100, 0, 0);

    // Odd length: last beat zero-padded.
    preds[0] = 32'd7; preds[1] = 32'd8; preds[2] = 32'd9;
    run(3, 200, 100, 0, 0);

    // Empty run.
    run(0, 300, 100, 0, 0);

    // Maximum burst with heavy channel back-pressure.
    for (int i = 0; i < 5100; i++) preds[i] = $urandom;
    run(5000, 1000, 30, 0, 0);

    // Control request stalled for 50 cycles.
    run(6, 50, 100, 50, 0);

    // Reset mid-DATA after 3 beats, then a fresh 2-sample run.
    run(10, 400, 100, 0, 3);
    do_reset();
    preds[0] = 32'd11; preds[1] = 32'd12;
    run(2, 500, 100, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
